// File: rtl/qaddsub_pipe_pkg.sv
// Shared types and constants for the sign-magnitude add/subtract pipeline.
package qaddsub_pipe_pkg;
`include "qmath_defs.vh"

    typedef enum logic {
        OP_ADD = `QM_OP_ADD,
        OP_SUB = `QM_OP_SUB
    } op_e;

    localparam int                   OVF_CNT_W   = 16;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

endpackage

// File: rtl/qaddsub_core.sv
// Sign-magnitude add/subtract execute logic: purely combinational, zero latency,
// no flow control of its own (the enclosing pipeline stage owns backpressure).
`include "qmath_defs.vh"

module qaddsub_core
    import qaddsub_pipe_pkg::*;
#(
    parameter int N        = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic         sign_a_i,
    input  logic         sign_b_i,
    input  logic [N-2:0] mag_a_i,
    input  logic [N-2:0] mag_b_i,
    input  logic         a_ge_b_i,
    output logic [N-1:0] res_o,
    output logic         ovf_o
);

    logic [N-1:0] sum;
    logic [N-2:0] diff;
    logic [N-2:0] mag;
    logic         sign;

    always_comb begin
        sum   = {1'b0, mag_a_i} + {1'b0, mag_b_i};
        diff  = a_ge_b_i ? (mag_a_i - mag_b_i) : (mag_b_i - mag_a_i);
        sign  = `QM_SIGN_POS;
        mag   = '0;
        ovf_o = 1'b0;
        if (sign_a_i == sign_b_i) begin
            sign  = sign_a_i;
            ovf_o = sum[N-1];
            mag   = (ovf_o && SATURATE) ? `QM_MAG_MAX(N) : sum[N-2:0];
        end else begin
            sign = a_ge_b_i ? sign_a_i : sign_b_i;
            mag  = diff;
        end
        // A zero magnitude (including a wrapped overflow) is always +0.
        if (mag == '0) begin
            sign = `QM_SIGN_POS;
        end
        res_o = {sign, mag};
    end

endmodule

// File: rtl/qmath_defs.vh
// Shared qMath encodings: operation codes and sign-magnitude helper constants.
`ifndef QMATH_DEFS_VH
`define QMATH_DEFS_VH

`define QM_OP_ADD      1'b0
`define QM_OP_SUB      1'b1
`define QM_SIGN_POS    1'b0
`define QM_SIGN_NEG    1'b1
`define QM_SIGN_IDX(n) ((n)-1)
`define QM_MAG_MAX(n)  {((n)-1){1'b1}}

`endif

// File: rtl/qaddsub_pipe.sv
// Two-stage sign-magnitude add/subtract: decode then execute, 2-cycle latency, 1/cycle.
// Valid/ready both sides; each stage advances when empty or when the next stage advances.
module qaddsub_pipe
    import qaddsub_pipe_pkg::*;
#(
    parameter int N        = 32,
    parameter int Q        = 15,
    parameter bit SATURATE = 1'b1,
    parameter int TW       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [N-1:0]         s_a,
    input  logic [N-1:0]         s_b,
    input  logic                 s_op,
    input  logic [TW-1:0]        s_tag,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N-1:0]         m_data,
    output logic [TW-1:0]        m_tag,
    output logic                 m_ovf,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    if (N < 4 || Q >= N - 1) begin : g_param_check
        $error("qaddsub_pipe: requires N >= 4 and Q < N-1");
    end

    typedef struct packed {
        logic          sign_a;
        logic          sign_b;
        logic [N-2:0]  mag_a;
        logic [N-2:0]  mag_b;
        logic          a_ge_b;
        logic [TW-1:0] tag;
    } s1_t;

    s1_t                  s1_d, s1_q;
    logic                 s1_vld_q;
    logic                 rdy_en_q;
    logic                 m_vld_q;
    logic [N-1:0]         m_data_q;
    logic [TW-1:0]        m_tag_q;
    logic                 m_ovf_q;
    logic [OVF_CNT_W-1:0] cnt_q, cnt_d;
    logic                 s2_adv;
    logic                 s1_load;
    logic [N-1:0]         core_res;
    logic                 core_ovf;

    // Negative zero operands are folded to +0 here so the execute stage never sees them.
    always_comb begin
        s1_d.mag_a  = s_a[N-2:0];
        s1_d.mag_b  = s_b[N-2:0];
        s1_d.sign_a = s_a[N-1] && (s1_d.mag_a != '0);
        s1_d.sign_b = (s_b[N-1] ^ (s_op == OP_SUB)) && (s1_d.mag_b != '0);
        s1_d.a_ge_b = s1_d.mag_a >= s1_d.mag_b;
        s1_d.tag    = s_tag;
    end

    assign s2_adv  = !m_vld_q || m_ready;
    assign s_ready = rdy_en_q && (!s1_vld_q || s2_adv);
    assign s1_load = s_valid && s_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (m_vld_q && m_ready && m_ovf_q && (cnt_q != OVF_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    qaddsub_core #(
        .N        (N),
        .SATURATE (SATURATE)
    ) u_core (
        .sign_a_i (s1_q.sign_a),
        .sign_b_i (s1_q.sign_b),
        .mag_a_i  (s1_q.mag_a),
        .mag_b_i  (s1_q.mag_b),
        .a_ge_b_i (s1_q.a_ge_b),
        .res_o    (core_res),
        .ovf_o    (core_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q <= 1'b0;
            s1_vld_q <= 1'b0;
            m_vld_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            cnt_q    <= cnt_d;
            if (s2_adv) begin
                m_vld_q <= s1_vld_q;
            end
            if (s_ready) begin
                s1_vld_q <= s_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            m_data_q <= '0;
            m_tag_q  <= '0;
            m_ovf_q  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_q <= s1_d;
            end
            if (s2_adv && s1_vld_q) begin
                m_data_q <= core_res;
                m_tag_q  <= s1_q.tag;
                m_ovf_q  <= core_ovf;
            end
        end
    end

    assign m_valid   = m_vld_q;
    assign m_data    = m_data_q;
    assign m_tag     = m_tag_q;
    assign m_ovf     = m_ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: doc/qaddsub_pipe.md
QADDSUB_PIPE -- requirements
Module: qaddsub_pipe

Interface
REQ-001 SHALL have parameter N, default 32, total word width in bits (sign + magnitude), N >= 4.
REQ-002 SHALL have parameter Q, default 15, fractional bits; Q < N-1. Q does not affect the arithmetic and is carried for consistency with other qMath blocks.
REQ-003 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = wrap the magnitude.
REQ-004 SHALL have parameter TW, default 4, sideband tag width.
REQ-005 SHALL have clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have s_valid, input, 1 bit: an operand pair is offered.
REQ-008 SHALL have s_ready, output, 1 bit: the block accepts the operand pair.
REQ-009 SHALL have s_a and s_b, input, N bits each: sign-magnitude Q-format operands (bit N-1 is the sign).
REQ-010 SHALL have s_op, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-011 SHALL have s_tag, input, TW bits: passed through unchanged with its result.
REQ-012 SHALL have m_valid, output, 1 bit: a result is presented.
REQ-013 SHALL have m_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL have m_data, output, N bits: sign-magnitude result.
REQ-015 SHALL have m_tag, output, TW bits: tag of the result.
REQ-016 SHALL have m_ovf, output, 1 bit: the result overflowed; qualified by m_valid.
REQ-017 SHALL have ovf_count, output, 16 bits: count of overflowed results accepted downstream.

Function
REQ-018 SHALL transfer an input on each clk edge where s_valid=1 and s_ready=1, and an output on each edge where m_valid=1 and m_ready=1.
REQ-019 SHALL implement two register stages:
  - S1 (decode): register the effective sign of b (sign of b XOR op), the magnitudes, the magnitude compare (|a| >= |b|), and the tag.
  - S2 (execute): add or subtract the magnitudes, then apply the sign, saturation, overflow and zero rules.
REQ-020 SHALL have a latency of exactly 2 cycles from input transfer to m_valid when m_ready stays high, and a throughput of 1 result per cycle.
REQ-021 SHALL advance each stage when it is empty or the next stage is advancing, so that s_ready = !S1_valid || S1 advancing; no bubbles and no loss under backpressure.
REQ-022 SHALL hold m_data, m_tag and m_ovf stable while m_valid=1 and m_ready=0.
REQ-023 For equal effective signs: magnitude = |a| + |b| in N bits; sign = sign of a.
REQ-024 For differing effective signs: magnitude = larger minus smaller; sign = sign of the larger magnitude.
REQ-025 SHALL treat an input of 1 followed by all zeros (negative zero) as +0.
REQ-026 SHALL never output negative zero: a zero magnitude forces sign=0.
REQ-027 SHALL set m_ovf=1 when the same-sign sum carries out of bit N-2.
REQ-028 On overflow with SATURATE=1, the magnitude SHALL be all ones (2^(N-1)-1) with the sign of the sum.
REQ-029 On overflow with SATURATE=0, the magnitude SHALL be the low N-1 bits of the sum with the sign of the sum.
REQ-030 SHALL increment ovf_count on each output transfer with m_ovf=1, saturating at 0xFFFF (no wrap).
REQ-031 SHALL deliver results in input order, each with its own tag.

Reset
REQ-032 While rst=1, SHALL drive s_ready=0, m_valid=0, m_data=0, m_tag=0, m_ovf=0 and ovf_count=0, and clear both stage valid flags immediately and asynchronously.
REQ-033 On reset mid-operation, SHALL discard all in-flight operands; none may appear after reset deasserts.
REQ-034 SHALL assert s_ready on the first clk edge after rst deasserts.

Structure
REQ-035 SHALL place the op encodings (OP_ADD=0, OP_SUB=1) and the sign-magnitude helper constants in the shared qMath include file qmath_defs.vh.
REQ-036 SHALL implement the S2 combinational arithmetic (REQ-023 to REQ-029) in one sub-module, qaddsub_core, instantiated once.

Verification (N=16, Q=8, SATURATE=1 unless stated)
REQ-037 Mixed signs: a=0x0180, b=0x8080, op=0 -> m_data=0x0100, m_ovf=0, 2 cycles later.
REQ-038 Subtract: a=0x0100, b=0x0180, op=1 -> 0x8080. Negative zero: a=0x0080, b=0x8080, op=0 -> 0x0000 (sign clear). Input 0x8000 + 0x0000 -> 0x0000.
REQ-039 Overflow: a=0x7FFF, b=0x0001, op=0 -> 0x7FFF, m_ovf=1, ovf_count=1. The same case with SATURATE=0 -> 0x0000, m_ovf=1.
REQ-040 Backpressure: hold m_ready=0 and offer tags 1,2,3. Required: s_ready drops after 2 accepts, m_data/m_tag stay stable, and after m_ready=1 the tags emerge in order 1,2,3 with no loss.
REQ-041 Streaming: 100 back-to-back random pairs with m_ready=1 -> 100 results at 1 per cycle, all matching the reference model.
REQ-042 Reset mid-operation: assert rst with 2 results in flight. Required: m_valid=0 and ovf_count=0 at once, and no stale result after release.
